// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between load/store (0),
// instruction fetch (1) and display/IO (2); one access in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned ADDR_BITS    = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             req,
    input  logic [2:0]             we,
    input  logic [3*ADDR_BITS-1:0] addr,
    input  logic [3*WIDTH-1:0]     wdata,
    output logic [2:0]             gnt,
    output logic [2:0]             done,
    output logic [WIDTH-1:0]       rdata,
    output logic                   busy,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    output logic                   mem_we,
    input  logic [WIDTH-1:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] last;
    logic [1:0] sel;
    logic       sel_we;
    logic [1:0] cnt;
    logic [1:0] p0, p1, p2;
    logic [1:0] win;
    logic       accept;

    // Scan order starts one past the last-served requester and wraps.
    always_comb begin
        p0 = 2'd0;
        p1 = 2'd1;
        p2 = 2'd2;
        case (last)
            2'd0: begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1: begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
        win = req[p0] ? p0 : (req[p1] ? p1 : p2);
    end

    always_comb begin
        accept    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE, RESP: begin
                accept    = |req;
                state_nxt = accept ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (sel_we || READ_LATENCY <= 1)
                    state_nxt = RESP;
                else
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 2'd1)
                    state_nxt = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 2'd2;
            sel       <= '0;
            sel_we    <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            state <= state_nxt;
            // mem_addr/mem_wdata double as the latched request and hold afterwards.
            if (accept) begin
                sel       <= win;
                last      <= win;
                sel_we    <= we[win];
                mem_addr  <= addr[win*ADDR_BITS +: ADDR_BITS];
                mem_wdata <= wdata[win*WIDTH +: WIDTH];
            end
            case (state)
                ACCESS: begin
                    if (!sel_we) begin
                        cnt <= 2'(READ_LATENCY - 1);
                        if (READ_LATENCY <= 1)
                            rdata <= mem_rdata;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1)
                        rdata <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign gnt    = (state == ACCESS) ? (3'b001 << sel) : 3'b000;
    assign done   = (state == RESP)   ? (3'b001 << sel) : 3'b000;
    assign mem_we = (state == ACCESS) && sel_we;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with READ_LATENCY=1 and one with READ_LATENCY=3,
// each in front of a small behavioural memory.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: READ_LATENCY = 1
    logic [2:0]  req_a, we_a, gnt_a, done_a;
    logic [47:0] addr_a, wdata_a;
    logic [15:0] rdata_a, maddr_a, mwdata_a, mrdata_a;
    logic        busy_a, mwe_a;

    // Instance B: READ_LATENCY = 3
    logic [2:0]  req_b, we_b, gnt_b, done_b;
    logic [47:0] addr_b, wdata_b;
    logic [15:0] rdata_b, maddr_b, mwdata_b, mrdata_b;
    logic        busy_b, mwe_b;

    mem_port_arbiter #(.WIDTH(16), .ADDR_BITS(16), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .gnt(gnt_a), .done(done_a), .rdata(rdata_a), .busy(busy_a),
        .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_we(mwe_a), .mem_rdata(mrdata_a)
    );

    mem_port_arbiter #(.WIDTH(16), .ADDR_BITS(16), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .busy(busy_b),
        .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_we(mwe_b), .mem_rdata(mrdata_b)
    );

    // Memory A: combinational read; contents reload on reset.
    logic [15:0] mem_a [256];
    always @(posedge clk) begin
        if (reset) begin
            mem_a[8'h10] <= 16'hBEEF;
            mem_a[8'h20] <= 16'h2222;
            mem_a[8'h30] <= 16'h3333;
        end else if (mwe_a) begin
            mem_a[maddr_a[7:0]] <= mwdata_a;
        end
    end
    assign mrdata_a = mem_a[maddr_a[7:0]];

    // Memory B: read data appears two register stages after the address.
    logic [15:0] mem_b [512];
    logic [15:0] pipe0, pipe1;
    always @(posedge clk) begin
        if (reset) begin
            mem_b[9'h000] <= 16'h0BAD;
            mem_b[9'h040] <= 16'h4444;
            mem_b[9'h100] <= 16'hD00D;
        end else if (mwe_b) begin
            mem_b[maddr_b[8:0]] <= mwdata_b;
        end
        pipe0 <= mem_b[maddr_b[8:0]];
        pipe1 <= pipe0;
    end
    assign mrdata_b = pipe1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [47:0] addr;
        logic [47:0] wdata;
        logic [2:0]  gnt;
        logic [15:0] maddr;
        logic [15:0] mwdata;
        logic        mwe;
        logic [15:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[8];
    logic [15:0] rr_data[3];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gcnt;
        int dcnt;
        logic bad_we;
        logic [2:0] eg, ed;

        vecs[0] = '{3'b001, 3'b000, {16'h0, 16'h0, 16'h0010}, 48'h0, 3'b001, 16'h0010, 16'h0, 1'b0, 16'hBEEF, 1};
        vecs[1] = '{3'b010, 3'b010, {16'h0, 16'h0020, 16'h0}, {16'h0, 16'h1234, 16'h0}, 3'b010, 16'h0020, 16'h1234, 1'b1, 16'hBEEF, 1};
        vecs[2] = '{3'b100, 3'b000, {16'h0020, 16'h0, 16'h0}, 48'h0, 3'b100, 16'h0020, 16'h0, 1'b0, 16'h1234, 1};
        vecs[3] = '{3'b001, 3'b001, {16'h0, 16'h0, 16'h0030}, {16'h0, 16'h0, 16'hCAFE}, 3'b001, 16'h0030, 16'hCAFE, 1'b1, 16'h1234, 1};
        vecs[4] = '{3'b001, 3'b000, {16'h0, 16'h0, 16'h0030}, 48'h0, 3'b001, 16'h0030, 16'h0, 1'b0, 16'hCAFE, 1};
        vecs[5] = '{3'b110, 3'b000, {16'h0020, 16'h0010, 16'h0}, 48'h0, 3'b010, 16'h0010, 16'h0, 1'b0, 16'hBEEF, 1};
        vecs[6] = '{3'b101, 3'b000, {16'h0030, 16'h0, 16'h0010}, 48'h0, 3'b100, 16'h0030, 16'h0, 1'b0, 16'hCAFE, 1};
        vecs[7] = '{3'b011, 3'b000, {16'h0, 16'h0010, 16'h0020}, 48'h0, 3'b001, 16'h0020, 16'h0, 1'b0, 16'h1234, 1};
        rr_data[0] = 16'hBEEF;
        rr_data[1] = 16'h2222;
        rr_data[2] = 16'h3333;

        reset = 1'b1;
        req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
        req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_a", {gnt_a, done_a, rdata_a, busy_a, maddr_a, mwdata_a, mwe_a}, '0);
        chk("reset_b", {gnt_b, done_b, rdata_b, busy_b, maddr_b, mwdata_b, mwe_b}, '0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            req_a = vecs[v].req; we_a = vecs[v].we;
            addr_a = vecs[v].addr; wdata_a = vecs[v].wdata;
            n = 0;
            do begin @(negedge clk); n++; end while (gnt_a == 3'b000 && n < 8);
            chk($sformatf("v%0d_gnt_delay", v), 64'(n), 64'd1);
            chk($sformatf("v%0d_gnt", v), gnt_a, vecs[v].gnt);
            chk($sformatf("v%0d_mem_addr", v), maddr_a, vecs[v].maddr);
            chk($sformatf("v%0d_mem_wdata", v), mwdata_a, vecs[v].mwdata);
            chk($sformatf("v%0d_mem_we", v), mwe_a, vecs[v].mwe);
            req_a = '0;
            n = 0;
            bad_we = 1'b0;
            do begin @(negedge clk); n++; if (mwe_a) bad_we = 1'b1; end
            while (done_a == 3'b000 && n < 8);
            chk($sformatf("v%0d_done_lat", v), 64'(n), 64'(vecs[v].lat));
            chk($sformatf("v%0d_done", v), done_a, vecs[v].gnt);
            chk($sformatf("v%0d_rdata", v), rdata_a, vecs[v].rdata);
            chk($sformatf("v%0d_we_pulse", v), bad_we, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_idle", v), {busy_a, gnt_a}, 4'b0);
        end

        // Requester 0 drops req right after the accept edge, before gnt is seen.
        req_a = 3'b001; we_a = '0; addr_a = {32'h0, 16'h0010};
        @(posedge clk);
        #1 req_a = '0;
        @(negedge clk);
        chk("drop_gnt", gnt_a, 3'b001);
        gcnt = 0; dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (gnt_a != 3'b000) gcnt++;
            if (done_a == 3'b001) dcnt++;
        end
        chk("drop_extra_gnt", 64'(gcnt), 64'd0);
        chk("drop_done_count", 64'(dcnt), 64'd1);
        chk("drop_rdata", rdata_a, 16'hBEEF);

        // Reset restores pointer to 2; all three hold reads continuously.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_a = 3'b111; we_a = '0;
        addr_a = {16'h0030, 16'h0020, 16'h0010};
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            eg = (c % 2 == 1) ? (3'b001 << (((c - 1) / 2) % 3)) : 3'b000;
            ed = (c % 2 == 0) ? (3'b001 << (((c - 2) / 2) % 3)) : 3'b000;
            chk($sformatf("rr%0d_gnt", c), gnt_a, eg);
            chk($sformatf("rr%0d_done", c), done_a, ed);
            if (c % 2 == 0)
                chk($sformatf("rr%0d_rdata", c), rdata_a, rr_data[((c - 2) / 2) % 3]);
            if (c == 12) req_a = '0;
        end
        @(negedge clk);
        chk("rr_idle", busy_a, 1'b0);

        // READ_LATENCY=3 read by requester 2.
        req_b = 3'b100; we_b = '0; addr_b = {16'h0100, 32'h0};
        n = 0;
        do begin @(negedge clk); n++; end while (gnt_b == 3'b000 && n < 8);
        chk("lat3_gnt_delay", 64'(n), 64'd1);
        chk("lat3_gnt", gnt_b, 3'b100);
        chk("lat3_addr_access", maddr_b, 16'h0100);
        req_b = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("lat3_c%0d_addr", c), maddr_b, 16'h0100);
            chk($sformatf("lat3_c%0d_we", c), mwe_b, 1'b0);
            chk($sformatf("lat3_c%0d_done", c), done_b, (c == 3) ? 3'b100 : 3'b000);
            chk($sformatf("lat3_c%0d_rdata", c), rdata_b, (c == 3) ? 16'hD00D : 16'h0000);
        end
        @(negedge clk);
        chk("lat3_idle", busy_b, 1'b0);

        // Reset during WAIT of a requester 1 read.
        req_b = 3'b010; addr_b = {16'h0, 16'h0040, 16'h0};
        n = 0;
        do begin @(negedge clk); n++; end while (gnt_b == 3'b000 && n < 8);
        chk("rst_gnt", gnt_b, 3'b010);
        req_b = '0;
        @(negedge clk);
        chk("rst_in_wait", {busy_b, done_b}, 4'b1000);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {gnt_b, done_b, rdata_b, busy_b, maddr_b, mwdata_b, mwe_b}, '0);
        reset = 1'b0;
        dcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_b != 3'b000) dcnt++;
        end
        chk("rst_no_done", 64'(dcnt), 64'd0);
        req_b = 3'b011; addr_b = {16'h0, 16'h0040, 16'h0100};
        n = 0;
        do begin @(negedge clk); n++; end while (gnt_b == 3'b000 && n < 8);
        chk("rst_first_gnt", gnt_b, 3'b001);
        req_b = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (done_b == 3'b000 && n < 8);
        chk("rst_done", done_b, 3'b001);
        chk("rst_done_lat", 64'(n), 64'd3);
        chk("rst_rdata", rdata_b, 16'hD00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
